// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo
//  Purpose  : Receive-side byte FIFO placed behind a UART receiver. Bytes are
//             pushed by the receiver's one-cycle done strobe and popped by a
//             consumer. The head byte is presented first-word-fall-through.
//             A push at full is dropped (sticky overflow) unless a pop occurs
//             in the same cycle. A pop at empty is ignored and reported by a
//             one-cycle underflow pulse.
//
//  Ports    : BCLK        - rising-edge clock (receiver oversample clock)
//             reset       - synchronous active-high reset
//             rx_dout     - byte from the receiver
//             rx_done_tk  - write strobe (one attempt per high cycle)
//             rd_en       - consumer pop request
//             ovf_clr     - clears the sticky overflow flag
//             rd_data     - head-of-queue byte, 0 while empty
//             empty/full/almost_full - occupancy flags decoded from count
//             count       - occupancy, 0..DEPTH
//             overflow    - sticky, set when a byte is dropped
//             underflow   - one-cycle pulse after an ignored pop
//
//  Revision : 1.0 - initial release
// ============================================================================
module rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_BITS   = $clog2(DEPTH),
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                  BCLK,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_dout,
    input  logic                  rx_done_tk,
    input  logic                  rd_en,
    input  logic                  ovf_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_BITS:0] c_DEPTH = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] c_AFULL = AFULL_LEVEL[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] c_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0]  r_wr_ptr;
    logic [ADDR_BITS-1:0]  r_rd_ptr;
    logic [ADDR_BITS:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_drop;

    // Flags come straight from the registered count so they never glitch.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // A pop frees a slot in the same cycle, so a push at full is still
    // accepted when it coincides with a real pop.
    assign w_rd_ok = rd_en & ~w_empty;
    assign w_wr_ok = rx_done_tk & (~w_full | w_rd_ok);
    assign w_drop  = rx_done_tk & ~w_wr_ok;

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge BCLK) begin
        if (w_wr_ok && !reset) begin
            r_mem[r_wr_ptr] <= rx_dout;
        end
    end

    always_ff @(posedge BCLK) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + c_ONE;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - c_ONE;
            end

            // A drop in the same cycle as a clear must leave the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end

            r_underflow <= rd_en & w_empty;
        end
    end

    // First-word-fall-through head; forced to zero while nothing is queued.
    assign rd_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= c_AFULL);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Clock: BCLK, the same oversample clock as the UART receiver. Reset: reset.
REQ-002 Parameter DATA_WIDTH, default 8: byte width, equal to the receiver's DATA_WIDTH.
REQ-003 Parameter DEPTH, default 16: number of entries; must be a power of 2 and at least 4.
REQ-004 Parameter ADDR_BITS, default $clog2(DEPTH): pointer width.
REQ-005 Parameter AFULL_LEVEL, default DEPTH-2: almost_full threshold.
REQ-006 BCLK  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 rx_dout  input  DATA_WIDTH  received byte from the UART receiver.
REQ-009 rx_done_tk  input  1  one-cycle write strobe from the receiver; rx_dout is valid while it is high.
REQ-010 rd_en  input  1  consumer pop request.
REQ-011 ovf_clr  input  1  clears the sticky overflow flag.
REQ-012 rd_data  output  DATA_WIDTH  head-of-queue byte (first-word-fall-through).
REQ-013 empty  output  1  high when count==0.
REQ-014 full  output  1  high when count==DEPTH.
REQ-015 almost_full  output  1  high when count>=AFULL_LEVEL.
REQ-016 count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  sticky; set when a byte is dropped.
REQ-018 underflow  output  1  one-cycle pulse on an ignored pop.

Function
REQ-019 Storage SHALL be a DEPTH x DATA_WIDTH register array with wr_ptr and rd_ptr of ADDR_BITS each, wrapping modulo DEPTH.
REQ-020 Effective read: rd_ok = rd_en & ~empty.
REQ-021 Effective write: wr_ok = rx_done_tk & (~full | rd_ok).
REQ-022 A write at full is accepted only when a pop occurs in the same cycle.
REQ-023 On wr_ok, mem[wr_ptr] SHALL take rx_dout and wr_ptr SHALL increment at the next BCLK edge.
REQ-024 On rd_ok, rd_ptr SHALL increment at the next BCLK edge.
REQ-025 count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
REQ-026 rd_data SHALL equal mem[rd_ptr] combinationally when empty=0, and 0 when empty=1.
REQ-027 There SHALL be no write-to-read bypass: a byte written into an empty FIFO appears on rd_data one cycle after its rx_done_tk.
REQ-028 Simultaneous rd_en and rx_done_tk while empty: the write is accepted, the pop is ignored, and underflow pulses.
REQ-029 rx_done_tk while full with no pop: the byte is dropped, pointers and count are unchanged, and overflow is set at the next edge.
REQ-030 overflow SHALL stay high until ovf_clr=1; a clear takes effect at the next edge.
REQ-031 If a drop and ovf_clr occur in the same cycle, the set SHALL win.
REQ-032 underflow SHALL be registered, high for exactly the one cycle after rd_en=1 with empty=1.
REQ-033 empty, full and almost_full SHALL be decoded from the registered count, so they are glitch-free and track count in the same cycle.
REQ-034 rx_done_tk held high for N consecutive cycles SHALL be treated as N write attempts; no edge detection is performed.
REQ-035 Latency: rx_done_tk to empty deasserting is 1 cycle; rd_en to the next byte appearing on rd_data is 1 cycle.

Reset
REQ-036 While reset=1 at a BCLK edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
REQ-037 Reset outputs: empty=1, full=0, almost_full=0, rd_data=0.
REQ-038 Array contents SHALL NOT be reset.
REQ-039 Reset asserted mid-operation SHALL discard all queued bytes.
REQ-040 Reset SHALL have priority over any simultaneous rx_done_tk, rd_en or ovf_clr.

Verification
REQ-041 Reset with DEPTH=16: empty=1, count=0, rd_data=0, overflow=0, underflow=0.
REQ-042 Write 0xA5 then 0x3C; pop twice: rd_data shows 0xA5, then 0x3C; empty returns to 1 after the second pop; count goes 0,1,2,1,0.
REQ-043 Write 16 bytes 0x00..0x0F: full=1 and almost_full=1 from count 14. Write a 17th byte 0xFF: it is dropped, overflow=1, count=16. Drain: bytes read 0x00..0x0F, no 0xFF.
REQ-044 At full, assert rd_en and rx_done_tk (0x77) together: count stays 16. After draining, 0x77 is last and overflow stays 0.
REQ-045 Pop while empty: underflow pulses for 1 cycle and count stays 0. Pop and write 0x11 together while empty: count=1, rd_data=0x11 next cycle, underflow=1.
REQ-046 Run 40 write/pop pairs for pointer wrap-around: data order preserved. Then assert reset mid-stream with count=5: count=0 and empty=1 next cycle, and a subsequent write reads back correctly.
